// File: rtl/fp_mult_seq_ctrl.sv
// fp_mult_seq_ctrl: sequential IEEE-754 multiplier controller.
// Accepts one operand pair (valid/ready), resolves special operands in one
// cycle, otherwise runs an iterative shift-add mantissa loop, normalises with
// truncation and holds the packed result until the consumer takes it.
// Optional build macro: FP_MULT_SEQ_CTRL_RADIX4_EN (two multiplier bits per
// MUL cycle; results are bit-identical to the default radix-2 build).
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid is held with stable data until that edge, ready may change freely.
module fp_mult_seq_ctrl #(
   parameter int WIDTH  = 32,
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flags,
   output logic [1:0]       state_dbg
);

   localparam int M1 = MANT_W + 1;
`ifdef FP_MULT_SEQ_CTRL_RADIX4_EN
   localparam int B = 2;
`else
   localparam int B = 1;
`endif
   localparam int NIT = (M1 + B - 1) / B;   // MUL iterations
   localparam int MW  = B * NIT;            // multiplier register, zero padded
   localparam int AW  = M1 + MW;            // accumulator width
   localparam int PW  = 2 * M1;             // meaningful product width
   localparam int CW  = $clog2(NIT) + 1;
   localparam logic [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
   localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, NORM = 2'd2, DONE = 2'd3} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [M1-1:0]      mcand_q, mcand_d;
   logic [MW-1:0]      mplier_q, mplier_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [EXP_W+1:0]   exp_q, exp_d;
   logic               sign_q, sign_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [2:0]         flags_q, flags_d;
`ifdef FP_MULT_SEQ_CTRL_RADIX4_EN
   logic [M1+1:0]      mcand3_q, mcand3_d;
`endif

   // Operand fields and classification (denormals count as zero)
   logic [EXP_W-1:0]  e1, e2;
   logic [MANT_W-1:0] m1, m2;
   logic nan1, nan2, inf1, inf2, zero1, zero2, inv;
   assign e1    = op1[WIDTH-2 -: EXP_W];
   assign e2    = op2[WIDTH-2 -: EXP_W];
   assign m1    = op1[MANT_W-1:0];
   assign m2    = op2[MANT_W-1:0];
   assign nan1  = (&e1) & (|m1);
   assign nan2  = (&e2) & (|m2);
   assign inf1  = (&e1) & ~(|m1);
   assign inf2  = (&e2) & ~(|m2);
   assign zero1 = ~(|e1);
   assign zero2 = ~(|e2);
   assign inv   = (zero1 & inf2) | (inf1 & zero2);

   // One shift-add step: add the selected multiple to the upper half, shift right by B
   logic [M1+B-1:0] addend, sum;
`ifdef FP_MULT_SEQ_CTRL_RADIX4_EN
   always_comb begin
      case (mplier_q[1:0])
         2'd0:    addend = '0;
         2'd1:    addend = {2'b00, mcand_q};
         2'd2:    addend = {1'b0, mcand_q, 1'b0};
         default: addend = mcand3_q;
      endcase
   end
`else
   assign addend = mplier_q[0] ? {1'b0, mcand_q} : '0;
`endif
   assign sum = {{B{1'b0}}, acc_q[AW-1:MW]} + addend;

   // Normalisation: product MSB selects the extraction window and exponent bump
   logic               msb;
   logic [EXP_W+1:0]   e_adj;
   logic [MANT_W-1:0]  mant;
   logic               ovf, unf;
   assign msb   = acc_q[PW-1];
   assign e_adj = exp_q + {{(EXP_W+1){1'b0}}, msb};
   assign mant  = msb ? acc_q[PW-2 -: MANT_W] : acc_q[PW-3 -: MANT_W];
   assign ovf   = ~e_adj[EXP_W+1] & (e_adj[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}});
   assign unf   = e_adj[EXP_W+1] | (e_adj == '0);

   // State register and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
`ifdef FP_MULT_SEQ_CTRL_RADIX4_EN
         mcand3_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         exp_q    <= exp_d;
         sign_q   <= sign_d;
         result_q <= result_d;
         flags_q  <= flags_d;
`ifdef FP_MULT_SEQ_CTRL_RADIX4_EN
         mcand3_q <= mcand3_d;
`endif
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      exp_d    = exp_q;
      sign_d   = sign_q;
      result_d = result_q;
      flags_d  = flags_q;
`ifdef FP_MULT_SEQ_CTRL_RADIX4_EN
      mcand3_d = mcand3_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d   = op1[WIDTH-1] ^ op2[WIDTH-1];
               mcand_d  = {1'b1, m1};
               mplier_d = MW'({1'b1, m2});
               acc_d    = '0;
               cnt_d    = '0;
               exp_d    = {2'b00, e1} + {2'b00, e2} - BIAS;
`ifdef FP_MULT_SEQ_CTRL_RADIX4_EN
               mcand3_d = {2'b00, 1'b1, m1} + {1'b0, 1'b1, m1, 1'b0};
`endif
               flags_d  = '0;
               state_d  = DONE;
               if (inv) begin
                  result_d = QNAN;
                  flags_d  = 3'b100;
               end else if (nan1 | nan2) begin
                  result_d = QNAN;
               end else if (inf1 | inf2) begin
                  result_d = {op1[WIDTH-1] ^ op2[WIDTH-1], {EXP_W{1'b1}}, {MANT_W{1'b0}}};
               end else if (zero1 | zero2) begin
                  result_d = {op1[WIDTH-1] ^ op2[WIDTH-1], {(WIDTH-1){1'b0}}};
               end else begin
                  state_d  = MUL;
               end
            end
         end
         MUL: begin
            acc_d    = {sum, acc_q[MW-1:B]};
            mplier_d = mplier_q >> B;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(NIT - 1)) state_d = NORM;
         end
         NORM: begin
            if (ovf) begin
               result_d = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
               flags_d  = 3'b010;
            end else if (unf) begin
               result_d = {sign_q, {(WIDTH-1){1'b0}}};
               flags_d  = 3'b001;
            end else begin
               result_d = {sign_q, e_adj[EXP_W-1:0], mant};
               flags_d  = 3'b000;
            end
            state_d = DONE;
         end
         default: begin
            if (out_ready) state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE) & ~rst;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign flags     = flags_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_fp_mult_seq_ctrl.sv
// Testbench for fp_mult_seq_ctrl: directed corner cases plus randomized
// operand pairs checked against a plain-arithmetic truncating reference model.
module tb_fp_mult_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] op1, op2, result;
   logic [2:0]  flags;
   logic [1:0]  state_dbg;

   int checks   = 0;
   int failures = 0;
   logic [34:0] exp_q[$];   // {flags, result}

`ifdef FP_MULT_SEQ_CTRL_RADIX4_EN
   localparam int LAT = 13;
`else
   localparam int LAT = 25;
`endif

   // clock / reset
   always #5 clk = ~clk;

   fp_mult_seq_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags),
      .state_dbg(state_dbg)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: IEEE rules with integer arithmetic, truncation, FTZ
   function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic [2:0] f, output bit sp);
      logic [7:0]  ea, eb;
      logic [22:0] ma, mb, frac;
      bit s, na, nb, ia, ib, za, zb;
      longint unsigned p;
      int e;
      ea = a[30:23]; eb = b[30:23]; ma = a[22:0]; mb = b[22:0];
      s  = a[31] ^ b[31];
      na = (ea == 8'hFF) && (ma != 0); nb = (eb == 8'hFF) && (mb != 0);
      ia = (ea == 8'hFF) && (ma == 0); ib = (eb == 8'hFF) && (mb == 0);
      za = (ea == 0); zb = (eb == 0);
      sp = 1'b1; f = 3'b000;
      if ((za && ib) || (ia && zb)) begin r = 32'h7FC00000; f = 3'b100; end
      else if (na || nb) r = 32'h7FC00000;
      else if (ia || ib) r = {s, 8'hFF, 23'h0};
      else if (za || zb) r = {s, 31'h0};
      else begin
         sp = 1'b0;
         p  = 64'({1'b1, ma}) * 64'({1'b1, mb});
         e  = int'(ea) + int'(eb) - 127;
         if (p >= 64'h8000_0000_0000) begin e++; frac = 23'(p >> 24); end
         else frac = 23'(p >> 23);
         if (e >= 255)     begin r = {s, 8'hFF, 23'h0}; f = 3'b010; end
         else if (e <= 0)  begin r = {s, 31'h0};        f = 3'b001; end
         else r = {s, 8'(e), frac};
      end
   endfunction

   function automatic logic [31:0] rand_op();
      int k;
      k = $urandom_range(0, 15);
      case (k)
         0:       return {1'($urandom), 8'h00, 23'($urandom)};          // zero / denormal
         1:       return {1'($urandom), 8'hFF, 23'h0};                  // inf
         2:       return {1'($urandom), 8'hFF, 23'($urandom) | 23'h1};  // nan
         default: return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      endcase
   endfunction

   // Driver: one operation from accept to handoff. elat = edges after the
   // accept edge until out_valid is seen (0 = visible right after accept).
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                        input logic [2:0] ef, input int elat, input bit noise, input int hold);
      int n, lat;
      logic [34:0] e;
      exp_q.push_back({ef, er});
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      check_val("in_ready_wait", in_ready, 1);
      in_valid = 1'b1; op1 = a; op2 = b;
      @(posedge clk); #1;
      if (noise) begin op1 = $urandom; op2 = $urandom; end
      else in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      in_valid = 1'b0;
      check_val("latency", lat, elat);
      e = exp_q.pop_front();
      check_val("result", result, e[31:0]);
      check_val("flags", flags, e[34:32]);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_val("hold_valid", out_valid, 1);
         check_val("hold_result", result, e[31:0]);
         check_val("hold_flags", flags, e[34:32]);
         check_val("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val("in_ready_after", in_ready, 1);
      check_val("valid_after", out_valid, 0);
   endtask

   initial begin
      logic [31:0] a, b, r;
      logic [2:0]  f;
      bit          sp;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op1 = '0; op2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_result", result, 0);
      check_val("rst_flags", flags, 0);
      check_val("rst_in_ready", in_ready, 0);
      check_val("rst_state", state_dbg, 0);
      rst = 1'b0;
      #1;
      check_val("post_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      do_op(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, LAT, 0, 0);
      do_op(32'hBFC00000, 32'h40000000, 32'hC0400000, 3'b000, LAT, 0, 0);
      do_op(32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100, 0,   0, 0);
      do_op(32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b000, 0,   0, 0);
      do_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, LAT, 0, 0);
      do_op(32'h00800000, 32'h00800000, 32'h00000000, 3'b001, LAT, 0, 0);
      do_op(32'h3F800000, 32'h40000000, 32'h40000000, 3'b000, LAT, 1, 5);
      do_op(32'h40400000, 32'h40400000, 32'h41100000, 3'b000, LAT, 0, 0);

      // reset in the middle of MUL discards the operation
      in_valid = 1'b1; op1 = 32'h3F800000; op2 = 32'h3F800000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_val("busy_valid", out_valid, 0);
      check_val("busy_in_ready", in_ready, 0);
      #1 rst = 1'b1;
      #1;
      check_val("midrst_valid", out_valid, 0);
      check_val("midrst_result", result, 0);
      check_val("midrst_flags", flags, 0);
      check_val("midrst_in_ready", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check_val("no_emit", out_valid, 0);
      check_val("idle_in_ready", in_ready, 1);
      do_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, LAT, 0, 0);

      // randomized pairs against the reference model
      for (int i = 0; i < 1500; i++) begin
         a = rand_op();
         b = rand_op();
         ref_mul(a, b, r, f, sp);
         do_op(a, b, r, f, sp ? 0 : LAT, ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
